// File: rtl/peripheral_uart_wb_driver.sv
// Wishbone master that programs a 16550-style UART after reset and then
// bridges its RBR/THR registers to valid/ready byte streams by polling LSR.
module peripheral_uart_wb_driver #(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       bus_err_o,
  output logic [7:0] lsr_o
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] ADR_RBR_THR = 3'd0;
  localparam logic [2:0] ADR_LSR     = 3'd5;

  typedef enum logic [2:0] {
    S_INIT,
    S_POLL,
    S_DECIDE,
    S_RD_RBR,
    S_WR_THR
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [2:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          init_done_q, init_done_d;
  logic          bus_err_q, bus_err_d;
  logic [7:0]    lsr_q, lsr_d;
  logic          tx_ready;

  logic [2:0]    req_adr;
  logic [7:0]    req_dat;
  logic          req_we;

  // Address/data/direction of the access the current state wants to issue.
  always_comb begin
    req_adr = '0;
    req_dat = '0;
    req_we  = 1'b0;
    case (state_q)
      S_INIT: begin
        req_we = 1'b1;
        case (step_q)
          3'd0:    begin req_adr = 3'd3; req_dat = 8'h83 | LCR_VAL; end
          3'd1:    begin req_adr = 3'd0; req_dat = DIVISOR[7:0];    end
          3'd2:    begin req_adr = 3'd1; req_dat = DIVISOR[15:8];   end
          3'd3:    begin req_adr = 3'd3; req_dat = LCR_VAL;         end
          3'd4:    begin req_adr = 3'd2; req_dat = FCR_VAL;         end
          3'd5:    begin req_adr = 3'd1; req_dat = 8'h00;           end
          default: begin req_adr = '0;   req_dat = '0;              end
        endcase
      end
      S_POLL:   req_adr = ADR_LSR;
      S_RD_RBR: req_adr = ADR_RBR_THR;
      S_WR_THR: begin
        req_adr = ADR_RBR_THR;
        req_dat = tx_byte_q;
        req_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: issue an access when the bus is idle, retire it on ack or timeout.
  // A cycle is only started from cyc=0, so every ack is followed by an idle cycle.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    tx_byte_d   = tx_byte_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    init_done_d = init_done_q;
    bus_err_d   = bus_err_q;
    lsr_d       = lsr_q;
    tx_ready    = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    if (state_q == S_DECIDE) begin
      if (lsr_q[0] && !rx_valid_q) begin
        state_d = S_RD_RBR;
      end else if (lsr_q[5]) begin
        tx_ready = 1'b1;
        if (tx_valid_i) begin
          tx_byte_d = tx_data_i;
          state_d   = S_WR_THR;
        end else begin
          state_d = S_POLL;
        end
      end else begin
        state_d = S_POLL;
      end
    end else if (!cyc_q) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      dat_d = req_dat;
      tmo_d = '0;
    end else if (wb_ack_i) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
      case (state_q)
        S_INIT: begin
          if (step_q == 3'd5) begin
            step_d      = '0;
            init_done_d = 1'b1;
            state_d     = S_POLL;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        S_POLL: begin
          lsr_d   = wb_dat_i;
          state_d = S_DECIDE;
        end
        S_RD_RBR: begin
          rx_data_d  = wb_dat_i;
          rx_valid_d = 1'b1;
          state_d    = S_POLL;
        end
        S_WR_THR: state_d = S_POLL;
        default: ;
      endcase
    end else if (tmo_q == TMO_LAST) begin
      cyc_d     = 1'b0;
      we_d      = 1'b0;
      adr_d     = '0;
      dat_d     = '0;
      bus_err_d = 1'b1;
      if (state_q == S_INIT) step_d = '0;
      else                   state_d = S_POLL;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // State and bus registers; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_INIT;
      step_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      tx_byte_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
      lsr_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      tx_byte_q   <= tx_byte_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      bus_err_q   <= bus_err_d;
      lsr_q       <= lsr_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_sel_o    = {3'b000, cyc_q};
  assign tx_ready_o  = tx_ready;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign init_done_o = init_done_q;
  assign bus_err_o   = bus_err_q;
  assign lsr_o       = lsr_q;

endmodule

// File: doc/peripheral_uart_wb_driver.md
Name: peripheral_uart_wb_driver

Overview:
Wishbone master that sits directly upstream of the UART Wishbone slave (16550-compatible register map, 8-bit data).
- After reset it programs the UART: line control, divisor latch, FIFO control and interrupt enable.
- It then polls the Line Status Register (LSR). It moves bytes between simple valid/ready byte streams and the Receiver Buffer Register (RBR) / Transmitter Holding Register (THR).
- Gives the MPSoC fabric a byte-stream console port without a processor driving the UART.

Parameters:
DIVISOR, 16'd27, baud divisor written to DLL/DLM (50 MHz / (16 x 115200)).
LCR_VAL, 8'h03, line control value after init (8N1, DLAB=0).
FCR_VAL, 8'h07, FIFO control value (enable, clear RX/TX FIFOs).
TIMEOUT, 255, maximum cycles waiting for wb_ack_i before abort.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_adr_o  out  3  UART register address
wb_dat_o  out  8  write data
wb_dat_i  in  8  read data
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_sel_o  out  4  byte select, constant 4'b0001 while cyc is high, 0 otherwise
wb_ack_i  in  1  slave acknowledge
tx_data_i  in  8  byte to transmit
tx_valid_i  in  1  tx byte valid
tx_ready_o  out  1  driver accepts tx byte this cycle
rx_data_o  out  8  received byte
rx_valid_o  out  1  rx byte valid, held until accepted
rx_ready_i  in  1  consumer accepts rx byte
init_done_o  out  1  UART programmed
bus_err_o  out  1  sticky: an access timed out
lsr_o  out  8  last LSR value read

Behaviour:
Reset values:
- All outputs 0.
- State = INIT, init step = 0.

Bus protocol:
- Every access is a single classic cycle: cyc, stb, adr, dat, we and sel are registered and held stable until the cycle where wb_ack_i=1.
- On that ack cycle: capture wb_dat_i (reads); cyc/stb go low on the next edge.
- At least one idle cycle (cyc=0) between accesses.
- Timeout counter starts at 0 when cyc rises and increments each cycle without ack.
- When it reaches TIMEOUT: drop cyc/stb, set bus_err_o (cleared only by reset).
- Timeout during INIT: restart init from step 0. Timeout elsewhere: go to POLL.

INIT sequence (writes, in order):
- adr3 = 8'h83 | LCR_VAL (DLAB=1)
- adr0 = DIVISOR[7:0]
- adr1 = DIVISOR[15:8]
- adr3 = LCR_VAL (DLAB=0)
- adr2 = FCR_VAL
- adr1 = 8'h00
- init_done_o rises the cycle after the last ack.

Main states, after INIT:
- POLL: read adr5; on ack store LSR into lsr_o, go to DECIDE.
- DECIDE, one cycle, priority order:
  - If LSR[0]=1 and rx_valid_o=0: go to RD_RBR.
  - Else if LSR[5]=1: tx_ready_o=1 this cycle only. If tx_valid_i=1, latch tx_data_i and go to WR_THR; otherwise go to POLL.
  - Else go to POLL.
- RD_RBR: read adr0. On ack: rx_data_o = wb_dat_i, rx_valid_o = 1, go to POLL.
- WR_THR: write adr0 with the latched byte; on ack go to POLL.

Stream handshakes:
- tx_ready_o is asserted only in DECIDE, and only when THRE=1 and no RX read was chosen. A transfer happens iff tx_valid_i & tx_ready_o.
- rx_valid_o clears on the edge where rx_valid_o & rx_ready_i.
- While rx_valid_o=1, RBR is never read; the UART FIFO absorbs backpressure.
- rx_data_o is stable while rx_valid_o=1.

Bus limits:
- One THR write per observed THRE; at most one access outstanding.

Reset mid-access:
- cyc/stb drop asynchronously; all state returns to reset values.

Test Plan:
1. Release reset, slave acks in 1 cycle -> write sequence (3,8'h83),(0,8'h1B),(1,8'h00),(3,8'h03),(2,8'h07),(1,8'h00); init_done_o=1 one cycle after last ack; cyc low between accesses.
2. After init, LSR returns 8'h60, tx_valid_i=1, tx_data_i=8'hA5 -> single-cycle tx_ready_o pulse, next access is write adr0=8'hA5 with we=1; next access is LSR read.
3. LSR=8'h61, RBR=8'h3C, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=8'h3C held. Later polls with LSR=8'h61 issue no adr0 read. Raising rx_ready_i for one cycle clears rx_valid_o; the next poll reads RBR.
4. LSR=8'h61 with tx_valid_i=1 and rx buffer empty -> RBR read first, tx_ready_o stays 0. The next LSR poll with LSR=8'h60 accepts the tx byte.
5. Slave never acks the first init write, TIMEOUT=255 -> cyc/stb drop after 255 cycles, bus_err_o=1 sticky, init restarts at step 0 (adr3=8'h83); init_done_o stays 0.
6. Assert wb_rst_i while cyc=1 during WR_THR -> cyc/stb/we 0 immediately, init_done_o/bus_err_o/rx_valid_o 0. After release the full init sequence repeats.
